pipe_sub_32bit: RTL and testbench
=================================

PIPE_SUB_32BIT -- requirements
Module: pipe_sub_32bit

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all flops rising-edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port i_valid, input, 1 bit: upstream operand pair valid.
REQ-004 SHALL have port o_ready, output, 1 bit: block accepts operands this cycle.
REQ-005 SHALL have port i_a, input, 32 bits: minuend, two's complement or unsigned.
REQ-006 SHALL have port i_b, input, 32 bits: subtrahend.
REQ-007 SHALL have port o_valid, output, 1 bit: result valid.
REQ-008 SHALL have port i_ready, input, 1 bit: downstream accepts result.
REQ-009 SHALL have port o_diff, output, 33 bits: signed difference, sign-extended.
REQ-010 SHALL have port o_borrow, output, 1 bit: unsigned borrow, i_a < i_b.
REQ-011 SHALL have port o_ovf, output, 1 bit: signed 32-bit overflow.

Function
REQ-012 SHALL compute the difference as i_a + ~i_b + 1 using two 16-bit carry-lookahead halves.
REQ-013 Stage 1 SHALL compute the low half with carry-in 1.
REQ-014 Stage 1 SHALL register diff[15:0], carry c16, and the upper operand halves i_a[31:16] and ~i_b[31:16].
REQ-015 Stage 2 SHALL compute the upper half with carry-in c16 and register the full result.
REQ-016 Latency SHALL be 2 cycles from input handshake (i_valid & o_ready) to o_valid, when unstalled.
REQ-017 Throughput SHALL be one result per cycle while i_ready=1.
REQ-018 o_diff SHALL equal sext33(i_a) - sext33(i_b) exactly.
REQ-019 o_diff[31:0] SHALL equal (i_a - i_b) mod 2^32.
REQ-020 o_diff[32] SHALL equal the true sign of the signed difference.
REQ-021 o_borrow SHALL equal the inverted carry-out of bit 31.
REQ-022 Each stage SHALL hold a valid bit s1_v/s2_v; output stage s2_v drives o_valid.
REQ-023 Stage 2 SHALL load when !s2_v or i_ready.
REQ-024 Stage 1 SHALL load when !s1_v or stage 2 loads.
REQ-025 o_ready SHALL be a combinational function of s1_v, s2_v and i_ready: o_ready = !s1_v | !s2_v | i_ready.
REQ-026 While o_valid=1 and i_ready=0, o_diff, o_borrow and o_ovf SHALL hold stable and no data SHALL be lost or duplicated.
REQ-027 Simultaneous input accept and output drain in the same cycle SHALL advance the pipeline with no bubble.
REQ-028 When i_valid=0 at an accept slot, a bubble SHALL propagate and o_valid SHALL deassert accordingly.
REQ-029 Operands SHALL be sampled only on the handshake; i_a and i_b are don't-care otherwise.

Reset
REQ-030 Assertion of i_rst_n=0 SHALL immediately clear s1_v, s2_v and o_valid, regardless of the clock.
REQ-031 During reset, o_diff, o_borrow and o_ovf SHALL read 0.
REQ-032 During reset, o_ready SHALL read 1 (empty pipeline).
REQ-033 Reset mid-operation SHALL discard all in-flight operations; none SHALL emerge after release.
REQ-034 After release, the first accepted pair SHALL appear exactly 2 cycles later.

Configuration
REQ-035 Macro SUB_OVF_FLAG_EN, when defined, SHALL compute o_ovf = o_diff[32] ^ o_diff[31], registered in stage 2 with the result.
REQ-036 When SUB_OVF_FLAG_EN is undefined, o_ovf SHALL be tied 0 and no overflow logic SHALL be synthesized; all other behaviour is unchanged.

Verification
REQ-037 Basic subtract: a=0x0000_0005, b=0x0000_0003, i_ready=1 -> 2 cycles later o_diff=0x0_0000_0002, o_borrow=0, o_ovf=0.
REQ-038 Unsigned borrow: a=0x0000_0000, b=0x0000_0001 -> o_diff=0x1_FFFF_FFFF, o_borrow=1, o_ovf=0.
REQ-039 Signed overflow, macro on: a=0x8000_0000, b=0x0000_0001 -> o_diff=0x1_7FFF_FFFF, o_ovf=1, o_borrow=0; with the macro off, o_ovf=0.
REQ-040 Cross-half carry: a=0x0001_0000, b=0x0000_0001 -> o_diff=0x0_0000_FFFF; 16 back-to-back random pairs -> 16 results in order, one per cycle.
REQ-041 Backpressure: fill pipeline, then hold i_ready=0 for 5 cycles -> o_ready=0 after two items, output stable; on i_ready=1 all items drain in order with none lost.
REQ-042 Async reset: assert i_rst_n=0 mid-stream between clock edges -> o_valid drops immediately; after release, no stale results appear.

Source files
------------

// File: rtl/pipe_sub_32bit.sv
// pipe_sub_32bit: two-stage pipelined 32-bit subtractor with valid/ready flow control.
// The difference is formed as a + ~b + 1 from two 16-bit carry-lookahead halves.
// Stage 1 computes the low half; stage 2 computes the high half and registers
// the 33-bit sign-extended difference, the unsigned borrow and (optionally) overflow.
// Optional feature: define SUB_OVF_FLAG_EN to build the signed-overflow flag o_ovf;
// without it o_ovf is tied low and no overflow logic exists.
module pipe_sub_32bit (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [32:0] o_diff,
   output logic        o_borrow,
   output logic        o_ovf
);

   // 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level
   // across the groups. Returns {carry_out, sum}.
   function automatic logic [16:0] cla16(input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic        cin);
      logic [15:0] g;
      logic [15:0] p;
      logic [15:0] c;
      logic [3:0]  gg;
      logic [3:0]  pg;
      logic [4:0]  gc;
      g = x & y;
      p = x ^ y;
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pg[k] = &p[4*k +: 4];
      end
      gc[0] = cin;
      gc[1] = gg[0] | (pg[0] & cin);
      gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
      gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
            | (pg[2] & pg[1] & pg[0] & cin);
      gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
            | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
      return {gc[4], p ^ c};
   endfunction

   logic        s1_v;
   logic        s2_v;
   logic        s1_load;
   logic        s2_load;
   logic [15:0] s1_diff_lo_reg;
   logic        s1_c16_reg;
   logic [15:0] s1_a_hi_reg;
   logic [15:0] s1_nb_hi_reg;
   logic [32:0] s2_diff_reg;
   logic        s2_borrow_reg;
   logic [16:0] lo_sum;
   logic [16:0] hi_sum;
   logic        diff_sign;

   // Load enables: the output stage refills when empty or draining; the first stage
   // refills when empty or when its content moves on, so accept and drain can overlap.
   assign s2_load = !s2_v | i_ready;
   assign s1_load = !s1_v | s2_load;
   assign o_ready = !s1_v | !s2_v | i_ready;

   // Low half with carry-in 1 completes the two's complement of b.
   assign lo_sum = cla16(i_a[15:0], ~i_b[15:0], 1'b1);

   // High half continues from the registered carry; bit 32 is the sign of the
   // 33-bit sum sext(a) + sext(~b) + 1, which is the exact signed difference.
   assign hi_sum    = cla16(s1_a_hi_reg, s1_nb_hi_reg, s1_c16_reg);
   assign diff_sign = s1_a_hi_reg[15] ^ s1_nb_hi_reg[15] ^ hi_sum[16];

   // Stage 1: capture low-half result and upper operand halves on the handshake.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_v           <= 1'b0;
         s1_diff_lo_reg <= '0;
         s1_c16_reg     <= 1'b0;
         s1_a_hi_reg    <= '0;
         s1_nb_hi_reg   <= '0;
      end else if (s1_load) begin
         s1_v <= i_valid;
         if (i_valid) begin
            s1_diff_lo_reg <= lo_sum[15:0];
            s1_c16_reg     <= lo_sum[16];
            s1_a_hi_reg    <= i_a[31:16];
            s1_nb_hi_reg   <= ~i_b[31:16];
         end
      end
   end

   // Stage 2: finish the upper half and register the full result; holds while stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_v          <= 1'b0;
         s2_diff_reg   <= '0;
         s2_borrow_reg <= 1'b0;
      end else if (s2_load) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_diff_reg   <= {diff_sign, hi_sum[15:0], s1_diff_lo_reg};
            s2_borrow_reg <= ~hi_sum[16];
         end
      end
   end

`ifdef SUB_OVF_FLAG_EN
   logic s2_ovf_reg;

   // Signed overflow: the 33-bit sign disagrees with the 32-bit result's sign.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_ovf_reg <= 1'b0;
      end else if (s2_load && s1_v) begin
         s2_ovf_reg <= diff_sign ^ hi_sum[15];
      end
   end

   assign o_ovf = s2_ovf_reg;
`else
   assign o_ovf = 1'b0;
`endif

   assign o_valid  = s2_v;
   assign o_diff   = s2_diff_reg;
   assign o_borrow = s2_borrow_reg;

endmodule

// File: tb/tb_pipe_sub_32bit.sv
// tb_pipe_sub_32bit: directed self-checking bench for pipe_sub_32bit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pipe_sub_32bit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        o_ready;
   logic        o_valid;
   logic [32:0] o_diff;
   logic        o_borrow;
   logic        o_ovf;

`ifdef SUB_OVF_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   // Hand-computed directed vectors: a, b, sext33(a)-sext33(b), borrow, raw overflow.
   localparam logic [31:0] DA  [5] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000,
                                       32'h0001_0000, 32'h7FFF_FFFF};
   localparam logic [31:0] DB  [5] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001,
                                       32'h0000_0001, 32'hFFFF_FFFF};
   localparam logic [32:0] DD  [5] = '{33'h0_0000_0002, 33'h1_FFFF_FFFF, 33'h1_7FFF_FFFF,
                                       33'h0_0000_FFFF, 33'h0_8000_0000};
   localparam logic        DBR [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam logic        DOV [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   // Backpressure items: 100-1, 0x12345678-0x02345678, 1-2.
   localparam logic [32:0] BPD [3] = '{33'h0_0000_0063, 33'h0_1000_0000, 33'h1_FFFF_FFFF};
   localparam logic        BPB [3] = '{1'b0, 1'b0, 1'b1};

   int n_checks = 0;
   int n_fail   = 0;

   logic [34:0] exp_q[$];
   logic [34:0] exp_e;
   logic [32:0] exp_d;
   logic [31:0] ta;
   logic [31:0] tb;
   int          got;

   pipe_sub_32bit dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_a      (a),
      .i_b      (b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_diff   (o_diff),
      .o_borrow (o_borrow),
      .o_ovf    (o_ovf)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      #3;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: actual %b required 0", o_valid); end
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: actual %b required 1", o_ready); end
      n_checks++; if (o_diff !== 33'h0) begin n_fail++; $display("FAIL rst_diff: actual %h required 0", o_diff); end
      n_checks++; if (o_borrow !== 1'b0) begin n_fail++; $display("FAIL rst_borrow: actual %b required 0", o_borrow); end
      n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: actual %b required 0", o_ovf); end
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: actual %b required 0", o_valid); end
      $display("test_reset done");
   endtask

   task automatic test_directed();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL dir_idle_%0d: actual %b required 0", i, o_valid); end
         i_ready = 1'b1; i_valid = 1'b1; a = DA[i]; b = DB[i];
         @(negedge clk);
         n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL dir_latency1_%0d: actual %b required 0", i, o_valid); end
         i_valid = 1'b0; a = $urandom; b = $urandom;
         @(negedge clk);
         n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL dir_valid_%0d: actual %b required 1", i, o_valid); end
         n_checks++; if (o_diff !== DD[i]) begin n_fail++; $display("FAIL dir_diff_%0d: actual %h required %h", i, o_diff, DD[i]); end
         n_checks++; if (o_borrow !== DBR[i]) begin n_fail++; $display("FAIL dir_borrow_%0d: actual %b required %b", i, o_borrow, DBR[i]); end
         n_checks++; if (o_ovf !== (DOV[i] & OVF_EN)) begin n_fail++; $display("FAIL dir_ovf_%0d: actual %b required %b", i, o_ovf, DOV[i] & OVF_EN); end
         $display("directed a=%h b=%h diff=%h borrow=%b ovf=%b", DA[i], DB[i], o_diff, o_borrow, o_ovf);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      i_ready = 1'b1;
      exp_q.delete();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         exp_v = (c >= 2) && (c <= 17);
         n_checks++; if (o_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid_c%0d: actual %b required %b", c, o_valid, exp_v); end
         n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_c%0d: actual %b required 1", c, o_ready); end
         if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL b2b_extra_c%0d: actual result %h required none", c, o_diff);
            end else begin
               exp_e = exp_q.pop_front();
               n_checks++; if ({o_ovf, o_borrow, o_diff} !== exp_e) begin
                  n_fail++;
                  $display("FAIL b2b_result_c%0d: actual ovf=%b borrow=%b diff=%h required ovf=%b borrow=%b diff=%h",
                           c, o_ovf, o_borrow, o_diff, exp_e[34], exp_e[33], exp_e[32:0]);
               end
               $display("b2b result diff=%h borrow=%b ovf=%b", o_diff, o_borrow, o_ovf);
            end
         end
         if (c < 16) begin
            ta = $urandom; tb = $urandom;
            if (c == 3) begin ta = 32'h8000_0000; tb = 32'h7FFF_FFFF; end
            exp_d = {ta[31], ta} - {tb[31], tb};
            exp_q.push_back({OVF_EN & (exp_d[32] ^ exp_d[31]), (ta < tb), exp_d});
            i_valid = 1'b1; a = ta; b = tb;
         end else begin
            i_valid = 1'b0; a = $urandom; b = $urandom;
         end
      end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: actual %0d left required 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      i_ready = 1'b0;
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_empty: actual %b required 1", o_ready); end
      i_valid = 1'b1; a = 32'd100; b = 32'd1;
      @(negedge clk);
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: actual %b required 1", o_ready); end
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_one: actual %b required 0", o_valid); end
      a = 32'h1234_5678; b = 32'h0234_5678;
      @(negedge clk);
      n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: actual %b required 0", o_ready); end
      a = 32'd1; b = 32'd2;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid_%0d: actual %b required 1", k, o_valid); end
         n_checks++; if (o_diff !== BPD[0]) begin n_fail++; $display("FAIL bp_hold_diff_%0d: actual %h required %h", k, o_diff, BPD[0]); end
         n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready_%0d: actual %b required 0", k, o_ready); end
         $display("bp stall %0d diff=%h ready=%b", k, o_diff, o_ready);
         @(negedge clk);
      end
      n_checks++; if (o_borrow !== BPB[0]) begin n_fail++; $display("FAIL bp_hold_borrow: actual %b required %b", o_borrow, BPB[0]); end
      i_ready = 1'b1;
      #1;
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release: actual %b required 1", o_ready); end
      @(negedge clk);
      i_valid = 1'b0;
      got = 0;
      for (int k = 0; k < 6; k++) begin
         if (o_valid === 1'b1) begin
            if (got >= 2) begin
               n_checks++; n_fail++;
               $display("FAIL bp_extra: actual result %h required none", o_diff);
            end else begin
               n_checks++; if (o_diff !== BPD[got+1]) begin n_fail++; $display("FAIL bp_drain_diff_%0d: actual %h required %h", got, o_diff, BPD[got+1]); end
               n_checks++; if (o_borrow !== BPB[got+1]) begin n_fail++; $display("FAIL bp_drain_borrow_%0d: actual %b required %b", got, o_borrow, BPB[got+1]); end
               n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_drain_ovf_%0d: actual %b required 0", got, o_ovf); end
               $display("bp drain diff=%h borrow=%b", o_diff, o_borrow);
            end
            got++;
         end
         @(negedge clk);
      end
      n_checks++; if (got != 2) begin n_fail++; $display("FAIL bp_drain_count: actual %0d required 2", got); end
   endtask

   task automatic test_async_reset();
      i_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         i_valid = 1'b1; a = 32'd10 + k; b = k;
      end
      @(negedge clk);
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ar_busy: actual %b required 1", o_valid); end
      #2 rst_n = 1'b0; i_valid = 1'b0;
      #1;
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_drop: actual %b required 0", o_valid); end
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: actual %b required 1", o_ready); end
      n_checks++; if (o_diff !== 33'h0) begin n_fail++; $display("FAIL ar_diff: actual %h required 0", o_diff); end
      n_checks++; if (o_borrow !== 1'b0) begin n_fail++; $display("FAIL ar_borrow: actual %b required 0", o_borrow); end
      $display("async reset asserted mid-cycle valid=%b", o_valid);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_stale_%0d: actual %b required 0", k, o_valid); end
      end
      i_valid = 1'b1; a = 32'h0001_0000; b = 32'h0000_0001;
      @(negedge clk);
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_first_early: actual %b required 0", o_valid); end
      i_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ar_first_valid: actual %b required 1", o_valid); end
      n_checks++; if (o_diff !== 33'h0_0000_FFFF) begin n_fail++; $display("FAIL ar_first_diff: actual %h required 0_0000_ffff", o_diff); end
      $display("post-reset first result diff=%h", o_diff);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
